// File: rtl/id_ex_if.sv
// id_ex_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_if #(parameter int XLEN = 32, parameter int CNT_W = 16) ();
  logic             id_valid;
  logic [11:0]      id_ctrl;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [14:0]      id_regs;
  logic [3:0]       id_funct;
  logic             ex_redirect;
  logic             stall;
  logic             ex_valid;
  logic [11:0]      ex_ctrl;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [14:0]      ex_regs;
  logic [3:0]       ex_funct;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm, id_regs, id_funct, ex_redirect,
    input  stall, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_regs, ex_funct, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm, id_regs, id_funct, ex_redirect,
    output stall, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_regs, ex_funct, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, redirect squash and perf counters
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  id_ex_if.slave  bus
);
  logic             ex_valid_q, ex_valid_d;
  logic [11:0]      ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [14:0]      ex_regs_q, ex_regs_d;
  logic [3:0]       ex_funct_q, ex_funct_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz, bubble;
  // hazard detection, bubble selection and next-state for every stage register and counter
  always_comb begin
    hz = bus.id_valid & ex_valid_q & ex_ctrl_q[8] & (|ex_regs_q[4:0])
       & ((ex_regs_q[4:0] == bus.id_regs[14:10]) | (ex_regs_q[4:0] == bus.id_regs[9:5]));
    bubble        = bus.ex_redirect | hz;
    ex_valid_d    = bubble ? 1'b0 : bus.id_valid;
    ex_ctrl_d     = (bubble | ~bus.id_valid) ? 12'h000 : bus.id_ctrl;
    ex_pc_d       = bubble ? '0 : bus.id_pc;
    ex_rs1_data_d = bubble ? '0 : bus.id_rs1_data;
    ex_rs2_data_d = bubble ? '0 : bus.id_rs2_data;
    ex_imm_d      = bubble ? '0 : bus.id_imm;
    ex_regs_d     = bubble ? '0 : bus.id_regs;
    ex_funct_d    = bubble ? '0 : bus.id_funct;
    stall_cnt_d   = (hz & ~bus.ex_redirect & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d   = (bus.ex_redirect & bus.id_valid & ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  // stage register and counters, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_regs_q     <= '0;
      ex_funct_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_regs_q     <= ex_regs_d;
      ex_funct_q    <= ex_funct_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end
  assign bus.stall       = hz & ~bus.ex_redirect;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rs1_data = ex_rs1_data_q;
  assign bus.ex_rs2_data = ex_rs2_data_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_regs     = ex_regs_q;
  assign bus.ex_funct    = ex_funct_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register, load-use stall, redirect squash and counters
module tb_id_ex_stage;
  localparam int CW = 8;
  localparam logic [11:0] LW   = 12'h14C;
  localparam logic [11:0] ADD  = 12'h006;
  localparam logic [11:0] ADDI = 12'h016;
  localparam logic [31:0] SAT  = 32'h0000_00FF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  id_ex_if #(.XLEN(32), .CNT_W(CW)) bus ();
  id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [14:0] regs(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {rs1, rs2, rd};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [14:0] r, input logic redir);
    bus.id_valid    = v;
    bus.id_ctrl     = c;
    bus.id_pc       = pc;
    bus.id_rs1_data = pc ^ 32'hAAAA_0000;
    bus.id_rs2_data = pc ^ 32'h0000_5555;
    bus.id_imm      = imm;
    bus.id_regs     = r;
    bus.id_funct    = pc[5:2];
    bus.ex_redirect = redir;
    #1;
  endtask
  initial begin
    drive(1'b0, 12'h0, 32'h0, 32'h0, 15'h0, 1'b0);
    #12 rst = 1'b0;
    chk("reset_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("reset_ex_ctrl", {20'b0, bus.ex_ctrl}, 32'h0);
    chk("reset_stall_cnt", {24'b0, bus.stall_cnt}, 32'h0);
    chk("reset_flush_cnt", {24'b0, bus.flush_cnt}, 32'h0);
    cyc();
    // T5: addi x7,x0,5
    drive(1'b1, ADDI, 32'h100, 32'h5, regs(5'd0, 5'd0, 5'd7), 1'b0);
    chk("t5_stall", {31'b0, bus.stall}, 32'h0);
    cyc();
    chk("t5_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("t5_ex_ctrl", {20'b0, bus.ex_ctrl}, 32'h016);
    chk("t5_ex_imm", bus.ex_imm, 32'h5);
    chk("t5_ex_rd", {27'b0, bus.ex_regs[4:0]}, 32'h7);
    chk("t5_ex_pc", bus.ex_pc, 32'h100);
    chk("t5_ex_rs1", bus.ex_rs1_data, 32'hAAAA_0100);
    chk("t5_ex_rs2", bus.ex_rs2_data, 32'h0000_5455);
    chk("t5_ex_funct", {28'b0, bus.ex_funct}, 32'h0);
    // T2: lw x5 then add x6,x5,x1
    drive(1'b1, LW, 32'h104, 32'h0, regs(5'd1, 5'd0, 5'd5), 1'b0);
    cyc();
    drive(1'b1, ADD, 32'h108, 32'h0, regs(5'd5, 5'd1, 5'd6), 1'b0);
    chk("t2_stall", {31'b0, bus.stall}, 32'h1);
    cyc();
    chk("t2_bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("t2_bubble_ctrl", {20'b0, bus.ex_ctrl}, 32'h0);
    chk("t2_bubble_pc", bus.ex_pc, 32'h0);
    chk("t2_stall_cnt", {24'b0, bus.stall_cnt}, 32'h1);
    chk("t2_stall_cleared", {31'b0, bus.stall}, 32'h0);
    cyc();
    chk("t2_add_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("t2_add_ctrl", {20'b0, bus.ex_ctrl}, 32'h006);
    chk("t2_add_pc", bus.ex_pc, 32'h108);
    chk("t2_add_regs", {17'b0, bus.ex_regs}, {17'b0, regs(5'd5, 5'd1, 5'd6)});
    chk("t2_stall_cnt_hold", {24'b0, bus.stall_cnt}, 32'h1);
    // T3: lw x0 then add x6,x0,x1
    drive(1'b1, LW, 32'h10C, 32'h0, regs(5'd1, 5'd0, 5'd0), 1'b0);
    cyc();
    drive(1'b1, ADD, 32'h110, 32'h0, regs(5'd0, 5'd1, 5'd6), 1'b0);
    chk("t3_stall", {31'b0, bus.stall}, 32'h0);
    cyc();
    chk("t3_add_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("t3_add_pc", bus.ex_pc, 32'h110);
    chk("t3_stall_cnt", {24'b0, bus.stall_cnt}, 32'h1);
    // T4: lw x5 in EX, consumer in ID, redirect same cycle
    drive(1'b1, LW, 32'h114, 32'h0, regs(5'd1, 5'd0, 5'd5), 1'b0);
    cyc();
    drive(1'b1, ADD, 32'h118, 32'h0, regs(5'd5, 5'd0, 5'd6), 1'b1);
    chk("t4_stall", {31'b0, bus.stall}, 32'h0);
    cyc();
    chk("t4_bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("t4_bubble_ctrl", {20'b0, bus.ex_ctrl}, 32'h0);
    chk("t4_flush_cnt", {24'b0, bus.flush_cnt}, 32'h1);
    chk("t4_stall_cnt", {24'b0, bus.stall_cnt}, 32'h1);
    // rs2-only dependency on a load stalls
    drive(1'b1, LW, 32'h11C, 32'h0, regs(5'd1, 5'd0, 5'd9), 1'b0);
    cyc();
    drive(1'b1, 12'h028, 32'h120, 32'h0, regs(5'd2, 5'd9, 5'd0), 1'b0);
    chk("rs2_stall", {31'b0, bus.stall}, 32'h1);
    cyc();
    chk("rs2_stall_cnt", {24'b0, bus.stall_cnt}, 32'h2);
    // invalid ID never stalls and loads a zero control bundle
    drive(1'b1, LW, 32'h124, 32'h0, regs(5'd1, 5'd0, 5'd5), 1'b0);
    cyc();
    drive(1'b0, ADD, 32'h128, 32'h0, regs(5'd5, 5'd5, 5'd6), 1'b0);
    chk("inv_stall", {31'b0, bus.stall}, 32'h0);
    cyc();
    chk("inv_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("inv_ex_ctrl", {20'b0, bus.ex_ctrl}, 32'h0);
    chk("inv_ex_pc", bus.ex_pc, 32'h128);
    // T1: asynchronous reset mid-stream
    drive(1'b1, ADD, 32'h12C, 32'h7, regs(5'd3, 5'd4, 5'd8), 1'b0);
    cyc();
    chk("t1_pre_valid", {31'b0, bus.ex_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t1_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("t1_ex_ctrl", {20'b0, bus.ex_ctrl}, 32'h0);
    chk("t1_ex_pc", bus.ex_pc, 32'h0);
    chk("t1_ex_imm", bus.ex_imm, 32'h0);
    chk("t1_ex_regs", {17'b0, bus.ex_regs}, 32'h0);
    chk("t1_stall_cnt", {24'b0, bus.stall_cnt}, 32'h0);
    chk("t1_flush_cnt", {24'b0, bus.flush_cnt}, 32'h0);
    drive(1'b0, 12'h0, 32'h0, 32'h0, 15'h0, 1'b0);
    rst = 1'b0;
    cyc();
    // T6: 2^CW+3 load-use stalls saturate stall_cnt
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      drive(1'b1, LW, 32'h200, 32'h0, regs(5'd1, 5'd0, 5'd5), 1'b0);
      cyc();
      drive(1'b1, ADD, 32'h204, 32'h0, regs(5'd5, 5'd1, 5'd6), 1'b0);
      cyc();
      if (i == 9) chk("t6_stall_cnt_10", {24'b0, bus.stall_cnt}, 32'd10);
    end
    chk("t6_stall_cnt_sat", {24'b0, bus.stall_cnt}, SAT);
    chk("t6_flush_cnt_zero", {24'b0, bus.flush_cnt}, 32'h0);
    // redirect squashes every cycle saturate flush_cnt
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      drive(1'b1, ADD, 32'h300, 32'h0, regs(5'd1, 5'd2, 5'd3), 1'b1);
      cyc();
    end
    chk("flush_cnt_sat", {24'b0, bus.flush_cnt}, SAT);
    chk("stall_cnt_still_sat", {24'b0, bus.stall_cnt}, SAT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
